// File: rtl/mux_8to1_if.sv
// Lane-select bus for mux_8to1: eight packed lanes plus index and enable in,
// registered lane, valid flag and index echo out.
interface mux_8to1_if #(
    parameter int unsigned LANE_W = 1
);
    logic [8*LANE_W-1:0] a;
    logic [2:0]          sel;
    logic                en;
    logic [LANE_W-1:0]   y;
    logic                y_valid;
    logic [2:0]          sel_q;

    modport master (
        output a, sel, en,
        input  y, y_valid, sel_q
    );

    modport slave (
        input  a, sel, en,
        output y, y_valid, sel_q
    );
endinterface

// File: rtl/mux_8to1.sv
// Registered 8-to-1 lane select: picks lane sel of a and presents it on y
// one cycle later, with a one-cycle valid pulse per capture.
module mux_8to1 #(
    parameter int unsigned LANE_W = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_8to1_if.slave  bus
);
    logic [LANE_W-1:0] lanes [8];
    logic [LANE_W-1:0] lane_c;

    // Unpack the bus into lanes; the index mux then never touches unselected bits.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            lanes[k] = bus.a[k*LANE_W +: LANE_W];
        end
    end

    assign lane_c = lanes[bus.sel];

    // Output registers; reset wins over en, y and sel_q hold while en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.y       <= '0;
            bus.sel_q   <= 3'd0;
            bus.y_valid <= 1'b0;
        end else if (bus.en) begin
            bus.y       <= lane_c;
            bus.sel_q   <= bus.sel;
            bus.y_valid <= 1'b1;
        end else begin
            bus.y_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_8to1.sv
// Scoreboard bench for mux_8to1 at LANE_W=1 and LANE_W=4: stimulus pushes
// expected outputs, per-instance monitors pop and compare after each edge.
module tb_mux_8to1;
    typedef struct packed {
        logic       v;
        logic [2:0] s;
        logic [3:0] y;
    } exp_t;

    logic clk;
    logic rst1_n;
    logic rst4_n;
    int   n_chk;
    int   n_fail;
    exp_t q1[$];
    exp_t q4[$];

    mux_8to1_if #(.LANE_W(1)) b1 ();
    mux_8to1_if #(.LANE_W(4)) b4 ();

    mux_8to1 #(.LANE_W(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(b1));
    mux_8to1 #(.LANE_W(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(b4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one vector to the 1-bit instance before the next edge; optional
    // glitching between edges that settles back before the edge.
    task automatic drv1(input logic r, input logic e, input logic [7:0] av,
                        input logic [2:0] s, input logic ey, input logic ev,
                        input logic [2:0] es, input bit glitch);
        exp_t x;
        @(negedge clk);
        rst1_n = r;
        b1.en  = e;
        b1.a   = av;
        b1.sel = s;
        x.v = ev;
        x.s = es;
        x.y = {3'b000, ey};
        q1.push_back(x);
        if (glitch) begin
            #1 b1.a = ~av; b1.sel = s + 3'd1; b1.en = ~e;
            #1 b1.a = av ^ 8'h5A; b1.sel = s + 3'd4;
            #1 b1.a = av; b1.sel = s; b1.en = e;
        end
    endtask

    task automatic drv4(input logic r, input logic e, input logic [31:0] av,
                        input logic [2:0] s, input logic [3:0] ey, input logic ev,
                        input logic [2:0] es);
        exp_t x;
        @(negedge clk);
        rst4_n = r;
        b4.en  = e;
        b4.a   = av;
        b4.sel = s;
        x.v = ev;
        x.s = es;
        x.y = ey;
        q4.push_back(x);
    endtask

    // Monitor for the 1-bit instance.
    always @(posedge clk) begin
        exp_t e1;
        #1;
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            n_chk++;
            if (b1.y_valid !== e1.v || b1.sel_q !== e1.s || b1.y !== e1.y[0]) begin
                n_fail++;
                $display("FAIL w1 t=%0t: got y=%b v=%b sel_q=%0d, want y=%b v=%b sel_q=%0d",
                         $time, b1.y, b1.y_valid, b1.sel_q, e1.y[0], e1.v, e1.s);
            end
        end
    end

    // Monitor for the 4-bit instance.
    always @(posedge clk) begin
        exp_t e4;
        #1;
        if (q4.size() > 0) begin
            e4 = q4.pop_front();
            n_chk++;
            if (b4.y_valid !== e4.v || b4.sel_q !== e4.s || b4.y !== e4.y) begin
                n_fail++;
                $display("FAIL w4 t=%0t: got y=%h v=%b sel_q=%0d, want y=%h v=%b sel_q=%0d",
                         $time, b4.y, b4.y_valid, b4.sel_q, e4.y, e4.v, e4.s);
            end
        end
    end

    initial begin
        logic [7:0] a8;
        n_chk  = 0;
        n_fail = 0;
        rst1_n = 1'b0;
        rst4_n = 1'b0;
        b1.en = 1'b0; b1.a = '0; b1.sel = 3'd0;
        b4.en = 1'b0; b4.a = '0; b4.sel = 3'd0;

        // Reset held two cycles with capture requested.
        drv1(1'b0, 1'b1, 8'hFF, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0);
        drv1(1'b0, 1'b1, 8'hFF, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0);

        // Hand examples on 8'b1010_0101, one with inter-edge glitching.
        drv1(1'b1, 1'b1, 8'hA5, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0);
        drv1(1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b1, 3'd1, 1'b1);
        drv1(1'b1, 1'b1, 8'hA5, 3'd7, 1'b1, 1'b1, 3'd7, 1'b0);
        drv1(1'b1, 1'b1, 8'hA5, 3'd6, 1'b0, 1'b1, 3'd6, 1'b1);

        // Hold: capture then three idle cycles with changed inputs.
        drv1(1'b1, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 3'd7, 1'b0);
        drv1(1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'd7, 1'b0);
        drv1(1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'd7, 1'b1);
        drv1(1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'd7, 1'b0);

        // Exhaustive sweep with a one-cycle reset injected mid-stream.
        for (int s = 0; s < 8; s++) begin
            for (int v = 0; v < 256; v++) begin
                a8 = 8'(v);
                if (s == 3 && v == 100)
                    drv1(1'b0, 1'b1, a8, 3'(s), 1'b0, 1'b0, 3'd0, 1'b0);
                drv1(1'b1, 1'b1, a8, 3'(s), a8[3'(s)], 1'b1, 3'(s), (v % 37) == 0);
            end
        end
        drv1(1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 3'd7, 1'b0);

        // Wide lanes: reset, then step sel over 32'h7654_3210, then idle.
        drv4(1'b0, 1'b1, 32'h7654_3210, 3'd5, 4'h0, 1'b0, 3'd0);
        drv4(1'b1, 1'b1, 32'h7654_3210, 3'd0, 4'h0, 1'b1, 3'd0);
        drv4(1'b1, 1'b1, 32'h7654_3210, 3'd1, 4'h1, 1'b1, 3'd1);
        drv4(1'b1, 1'b1, 32'h7654_3210, 3'd2, 4'h2, 1'b1, 3'd2);
        drv4(1'b1, 1'b1, 32'h7654_3210, 3'd3, 4'h3, 1'b1, 3'd3);
        drv4(1'b1, 1'b1, 32'h7654_3210, 3'd4, 4'h4, 1'b1, 3'd4);
        drv4(1'b1, 1'b1, 32'h7654_3210, 3'd5, 4'h5, 1'b1, 3'd5);
        drv4(1'b1, 1'b1, 32'h7654_3210, 3'd6, 4'h6, 1'b1, 3'd6);
        drv4(1'b1, 1'b1, 32'h7654_3210, 3'd7, 4'h7, 1'b1, 3'd7);
        drv4(1'b1, 1'b0, 32'hFEDC_BA98, 3'd0, 4'h7, 1'b0, 3'd7);
        drv4(1'b1, 1'b1, 32'hFEDC_BA98, 3'd2, 4'hA, 1'b1, 3'd2);

        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (q1.size() != 0 || q4.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d entries left, want 0/0", q1.size(), q4.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
